// File: rtl/hex_display_scanner.sv
// ---------------------------------------------------------------------------
// hex_display_scanner
//
// Time-multiplexes a 16-bit word onto a 4-digit common-anode style display.
// A prescaler divides clk down to one digit slot per DIV cycles; a 2-bit
// digit index walks slots 0..3. The displayed word is a snapshot taken at
// the end of each 4-digit frame, so the digits never tear mid-frame.
//
// Parameters:
//   DIV        clock cycles per digit slot (2..65535)
//
// Ports:
//   clk        clock, rising edge
//   clear_n    asynchronous active-low reset
//   value      16-bit word to display; nibble k goes to digit k
//   freeze     1 = keep the current snapshot at frame boundaries
//   blank_lz   1 = blank leading zero digits (digit 0 is never blanked)
//   digit      hex nibble of the active slot (always snap nibble idx)
//   dig_sel_n  active-low digit enables, bit k drives digit k
//   blank      1 when the current slot shows nothing
//   frame_done one-cycle pulse after the last slot of a frame ends
// ---------------------------------------------------------------------------
module hex_display_scanner #(
    parameter int unsigned DIV = 1000
) (
    input  logic        clk,
    input  logic        clear_n,
    input  logic [15:0] value,
    input  logic        freeze,
    input  logic        blank_lz,
    output logic [3:0]  digit,
    output logic [3:0]  dig_sel_n,
    output logic        blank,
    output logic        frame_done
);

    localparam logic [15:0] PRE_MAX = 16'(DIV - 1);

    logic [15:0] pre;
    logic [1:0]  idx;
    logic [15:0] snap;
    logic        tick;

    assign tick = (pre == PRE_MAX);

    // Scan state. frame_done is registered so it lines up with the first
    // cycle of the new frame, i.e. the cycle after the boundary edge.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            pre        <= 16'd0;
            idx        <= 2'd0;
            snap       <= 16'h0000;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (tick) begin
                pre <= 16'd0;
                idx <= idx + 2'd1;
                if (idx == 2'd3) begin
                    frame_done <= 1'b1;
                    if (!freeze) begin
                        snap <= value;
                    end
                end
            end else begin
                pre <= pre + 16'd1;
            end
        end
    end

    // A slot is a leading zero when its nibble and every higher nibble are
    // zero; build that as a chain from the top nibble down.
    logic z3, z2, z1;
    logic lz_slot;

    assign z3 = (snap[15:12] == 4'h0);
    assign z2 = z3 && (snap[11:8] == 4'h0);
    assign z1 = z2 && (snap[7:4] == 4'h0);

    always_comb begin
        lz_slot = 1'b0;
        case (idx)
            2'd3:    lz_slot = z3;
            2'd2:    lz_slot = z2;
            2'd1:    lz_slot = z1;
            default: lz_slot = 1'b0;
        endcase
    end

    always_comb begin
        digit = 4'h0;
        case (idx)
            2'd0:    digit = snap[3:0];
            2'd1:    digit = snap[7:4];
            2'd2:    digit = snap[11:8];
            default: digit = snap[15:12];
        endcase
    end

    // The first cycle of every slot (pre == 0) is dark so the previous
    // digit's segments can settle before the next enable goes low.
    always_comb begin
        dig_sel_n = 4'b1111;
        blank     = 1'b1;
        if ((pre != 16'd0) && !(blank_lz && lz_slot)) begin
            dig_sel_n = ~(4'b0001 << idx);
            blank     = 1'b0;
        end
    end

endmodule

// File: tb/tb_hex_display_scanner.sv
// ---------------------------------------------------------------------------
// tb_hex_display_scanner
//
// Directed bench for hex_display_scanner with DIV=4 (16-cycle frames).
// The bench counts cycles since reset release in cyc; after edge cyc the
// scanner sits in slot (cyc%16)/4, prescaler phase cyc%4, and a new
// snapshot is visible from every cyc that is a multiple of 16.
// ---------------------------------------------------------------------------
module tb_hex_display_scanner;

    localparam int DIV = 4;

    logic        clk;
    logic        clear_n;
    logic [15:0] value;
    logic        freeze;
    logic        blank_lz;
    logic [3:0]  digit;
    logic [3:0]  dig_sel_n;
    logic        blank;
    logic        frame_done;

    hex_display_scanner #(.DIV(DIV)) dut (
        .clk        (clk),
        .clear_n    (clear_n),
        .value      (value),
        .freeze     (freeze),
        .blank_lz   (blank_lz),
        .digit      (digit),
        .dig_sel_n  (dig_sel_n),
        .blank      (blank),
        .frame_done (frame_done)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected display for one frame: dig/sel nibble k and blk bit k
    // describe slot k during its lit phases (prescaler 1..3).
    typedef struct {
        logic [15:0] value;
        logic        lz;
        logic [15:0] dig;
        logic [15:0] sel;
        logic [3:0]  blk;
    } vec_t;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s (cyc %0d): got %h expected %h", name, cyc, act, exp);
    endtask

    // One clock, then sample 1 ns after the edge.
    task automatic step(input vec_t r);
        int slot, ph, zeros;
        @(posedge clk);
        #1;
        cyc++;
        slot = (cyc % 16) / 4;
        ph   = cyc % 4;
        chk("frame_done", 32'(frame_done), 32'((cyc % 16 == 0) && (cyc != 0)));
        zeros = 0;
        for (int b = 0; b < 4; b++) if (dig_sel_n[b] == 1'b0) zeros++;
        chk("one_sel_low", 32'(zeros <= 1), 32'd1);
        chk("digit", 32'(digit), 32'(r.dig[slot*4 +: 4]));
        if (ph == 0) begin
            chk("dead_sel", 32'(dig_sel_n), 32'hF);
            chk("dead_blank", 32'(blank), 32'd1);
        end else begin
            chk("sel", 32'(dig_sel_n), 32'(r.sel[slot*4 +: 4]));
            chk("blank", 32'(blank), 32'(r.blk[slot]));
        end
    endtask

    task automatic run_steps(input int n, input vec_t r);
        for (int i = 0; i < n; i++) step(r);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_sel"},   32'(dig_sel_n),  32'hF);
        chk({tag, "_blank"}, 32'(blank),      32'd1);
        chk({tag, "_digit"}, 32'(digit),      32'h0);
        chk({tag, "_fdone"}, 32'(frame_done), 32'd0);
    endtask

    vec_t vecs[8];
    vec_t zero_r, r;
    logic [15:0] loaded;

    initial begin
        vecs[0] = '{16'h1A2B, 1'b0, 16'h1A2B, 16'h7BDE, 4'b0000};
        vecs[1] = '{16'h0005, 1'b1, 16'h0005, 16'hFFFE, 4'b1110};
        vecs[2] = '{16'h0500, 1'b1, 16'h0500, 16'hFBDE, 4'b1000};
        vecs[3] = '{16'h0000, 1'b1, 16'h0000, 16'hFFFE, 4'b1110};
        vecs[4] = '{16'h0000, 1'b0, 16'h0000, 16'h7BDE, 4'b0000};
        vecs[5] = '{16'hF00F, 1'b1, 16'hF00F, 16'h7BDE, 4'b0000};
        vecs[6] = '{16'h00A0, 1'b1, 16'h00A0, 16'hFFDE, 4'b1100};
        vecs[7] = '{16'h1234, 1'b0, 16'h1234, 16'h7BDE, 4'b0000};
        zero_r  = '{16'h0000, 1'b0, 16'h0000, 16'h7BDE, 4'b0000};

        clear_n  = 1'b0;
        value    = 16'h0000;
        freeze   = 1'b0;
        blank_lz = 1'b0;

        // Reset state, before any edge and while edges run in reset.
        #2;
        chk_reset_outputs("rst0");
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("rst1");

        // Release away from the edge; first frame shows the zero snapshot.
        #3;
        clear_n = 1'b1;
        cyc = 0;
        run_steps(15, zero_r);

        // Table: inputs set just before a boundary, one full frame checked.
        foreach (vecs[i]) begin
            value    = vecs[i].value;
            blank_lz = vecs[i].lz;
            run_steps(16, vecs[i]);
        end

        // Freeze across two boundaries keeps 1234, release loads FFFF.
        freeze = 1'b1;
        value  = 16'hFFFF;
        run_steps(32, vecs[7]);
        freeze = 1'b0;
        r = '{16'hFFFF, 1'b0, 16'hFFFF, 16'h7BDE, 4'b0000};
        run_steps(16, r);

        // Mid-slot reset at idx 2: outputs drop without a clock edge.
        run_steps(10, r);
        chk("pre_rst_sel", 32'(dig_sel_n), 32'hB);
        #2;
        clear_n = 1'b0;
        #1;
        chk_reset_outputs("rst_mid");
        #4;
        clear_n = 1'b1;
        cyc = 0;
        run_steps(15, zero_r);
        run_steps(16, r);

        // blank_lz acts in the same cycle, no clock needed.
        value    = 16'h0005;
        blank_lz = 1'b0;
        r = '{16'h0005, 1'b0, 16'h0005, 16'h7BDE, 4'b0000};
        run_steps(10, r);
        blank_lz = 1'b1;
        #1;
        chk("lz_on_sel",   32'(dig_sel_n), 32'hF);
        chk("lz_on_blank", 32'(blank),     32'd1);
        chk("lz_on_digit", 32'(digit),     32'h0);
        blank_lz = 1'b0;
        #1;
        chk("lz_off_sel",   32'(dig_sel_n), 32'hB);
        chk("lz_off_blank", 32'(blank),     32'd0);
        run_steps(6, r);

        // value changes every cycle; digit follows only the boundary load.
        loaded = 16'h0005;
        for (int i = 0; i < 48; i++) begin
            value = 16'($urandom_range(0, 65535));
            if (cyc % 16 == 15) loaded = value;
            r = '{value, 1'b0, loaded, 16'h7BDE, 4'b0000};
            step(r);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
